// File: rtl/sound_pkg.sv
// Shared definitions for the sound path: FSM states, code width and the tone codes
// used by the game logic.
package sound_pkg;

   localparam int CLK_HZ  = 50_000_000;
   localparam int SOUND_W = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [SOUND_W-1:0] SND_SILENCE = 6'b000_000;
   localparam logic [SOUND_W-1:0] SND_STONE   = 6'b000_001;
   localparam logic [SOUND_W-1:0] SND_WIN     = 6'b000_010;
   localparam logic [SOUND_W-1:0] SND_CLICK   = 6'b000_011;

endpackage

// File: rtl/sound_arbiter_if.sv
// Bundle between the sound sources (master) and the arbiter (slave).
interface sound_arbiter_if
   import sound_pkg::*;
#(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]         req;
   logic [SOUND_W*NUM_REQ-1:0] code;
   logic [SOUND_W-1:0]         sound_out;
   logic                       sound_en;
   logic [NUM_REQ-1:0]         grant;
   logic [NUM_REQ-1:0]         done;
   logic [NUM_REQ-1:0]         pending;
   logic                       busy;

   modport master (
      output req, code,
      input  sound_out, sound_en, grant, done, pending, busy
   );

   modport slave (
      input  req, code,
      output sound_out, sound_en, grant, done, pending, busy
   );
endinterface

// File: rtl/sound_arbiter_rr_picker.sv
// Round-robin selector: first pending source strictly after the previous owner.
module rr_picker #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         pending,
   input  logic [$clog2(NUM_REQ)-1:0] last,
   output logic                       valid,
   output logic [NUM_REQ-1:0]         onehot,
   output logic [$clog2(NUM_REQ)-1:0] idx
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0] cand;

   always_comb begin
      // NOTE: every variable gets a default before the search so no path infers a latch.
      valid  = 1'b0;
      idx    = '0;
      cand   = '0;
      onehot = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(last) + k) % NUM_REQ);
         if (!valid && pending[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
      if (valid) onehot = NUM_REQ'(1) << idx;
   end
endmodule

// File: rtl/sound_arbiter.sv
// Shares one tone-code output among NUM_REQ sources: queue, round-robin grant,
// hold for DURATION cycles, then GAP silent cycles.
module sound_arbiter
   import sound_pkg::*;
#(
   parameter int                 NUM_REQ  = 4,
   parameter int                 DURATION = 50_000_000,
   parameter int                 GAP      = 2_500_000,
   parameter int                 CNT_W    = 26,
   parameter logic [SOUND_W-1:0] SILENCE  = SND_SILENCE
) (
   input logic              clock,
   input logic              resetn,
   sound_arbiter_if.slave   bus
);
   localparam int               IDX_W     = $clog2(NUM_REQ);
   localparam logic [CNT_W-1:0] DUR_LAST  = CNT_W'(DURATION - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
   localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

   state_t             state;
   logic [CNT_W-1:0]   timer;
   logic [NUM_REQ-1:0] pending_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [NUM_REQ-1:0] done_q;
   logic [SOUND_W-1:0] code_reg [NUM_REQ];
   logic [SOUND_W-1:0] sound_q;
   logic               sound_en_q;
   logic               busy_q;
   logic [IDX_W-1:0]   last;

   logic               pick_valid;
   logic [NUM_REQ-1:0] pick_onehot;
   logic [IDX_W-1:0]   pick_idx;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .pending (pending_q),
      .last    (last),
      .valid   (pick_valid),
      .onehot  (pick_onehot),
      .idx     (pick_idx)
   );

   always_ff @(posedge clock) begin
      if (resetn) begin
         state      <= ST_IDLE;
         timer      <= '0;
         pending_q  <= '0;
         grant_q    <= '0;
         done_q     <= '0;
         sound_q    <= SILENCE;
         sound_en_q <= 1'b0;
         busy_q     <= 1'b0;
         last       <= LAST_INIT;
         // NOTE: the small code store is cleared too, so nothing from before reset can leak out.
         for (int i = 0; i < NUM_REQ; i++) code_reg[i] <= '0;
      end else begin
         done_q    <= '0;
         pending_q <= pending_q | bus.req;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i]) code_reg[i] <= bus.code[SOUND_W*i +: SOUND_W];
         end

         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  grant_q    <= pick_onehot;
                  sound_q    <= code_reg[pick_idx];
                  sound_en_q <= 1'b1;
                  busy_q     <= 1'b1;
                  last       <= pick_idx;
                  timer      <= '0;
                  state      <= ST_PLAY;
                  // A fresh request from the winner in this cycle keeps it queued.
                  pending_q  <= (pending_q & ~pick_onehot) | bus.req;
               end
            end
            ST_PLAY: begin
               if (timer == DUR_LAST) begin
                  sound_en_q <= 1'b0;
                  grant_q    <= '0;
                  sound_q    <= SILENCE;
                  done_q     <= grant_q;
                  timer      <= '0;
                  if (GAP > 0) begin
                     state <= ST_GAP;
                  end else begin
                     state  <= ST_IDLE;
                     busy_q <= 1'b0;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_GAP: begin
               if (timer == GAP_LAST) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
                  timer  <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.sound_out = sound_q;
   assign bus.sound_en  = sound_en_q;
   assign bus.grant     = grant_q;
   assign bus.done      = done_q;
   assign bus.pending   = pending_q;
   assign bus.busy      = busy_q;
endmodule

// File: doc/sound_arbiter.md
Name: sound_arbiter

Overview:
- Shares the single 6-bit tone-code output among NUM_REQ sound sources (stone placement, win jingle, UI clicks), one sound at a time.
- Each source pulses a request with a code. The arbiter queues the request, grants round-robin, holds the code on the output for DURATION cycles, then inserts a GAP of silence.
- Sits between the game-logic sound sources and the tone generator. It replaces per-source hold counters with one shared timer.

Parameters:
- NUM_REQ, 4, number of requesting sources (2..8)
- DURATION, 50_000_000, cycles a granted sound is held (1 s at 50 MHz)
- GAP, 2_500_000, silent cycles after each sound; 0 = no gap state
- CNT_W, 26, timer width; must satisfy 2**CNT_W > max(DURATION, GAP)
- SILENCE, 6'b000_000, code driven on sound_out when not playing

Ports:
- clock  in  1  system clock, all logic on rising edge
- resetn  in  1  reset, synchronous, active-high (name kept per codebase; polarity fixed)
- req  in  NUM_REQ  per-source request, 1-cycle pulse or level; sampled every cycle
- code  in  6*NUM_REQ  per-source sound code; slice i = code[6i+5:6i], sampled when req[i]=1
- sound_out  out  6  code to tone generator; SILENCE unless playing
- sound_en  out  1  high exactly while a sound is playing
- grant  out  NUM_REQ  one-hot owner of current sound; 0 when not playing
- done  out  NUM_REQ  1-cycle pulse to source i when its sound finishes
- pending  out  NUM_REQ  per-source queued-request flags
- busy  out  1  high in PLAY or GAP

Behaviour:
- Reset, synchronous: every output and internal register is cleared in the cycle resetn is sampled high.
  - state=IDLE, pending=0, grant=0, done=0, sound_en=0, busy=0, sound_out=SILENCE, timer=0.
  - RR pointer last=NUM_REQ-1, so source 0 wins first.
- Reset mid-PLAY or mid-GAP aborts immediately. No done pulse is issued and all queued requests are dropped.
- Request capture: req[i]=1 at edge t sets pending[i] and loads code slice i into code_reg[i] at t.
  - A re-request while pending overwrites code_reg[i]; last code wins, and the request is not counted twice.
  - A request from the source that currently owns PLAY sets pending[i] and queues one replay. The playing code is unaffected.
- FSM states: IDLE, PLAY, GAP.
- IDLE: if pending != 0, select the first i with pending[i]=1, searching upward from last+1 modulo NUM_REQ.
  - At the next edge: grant=onehot(i), sound_out=code_reg[i], sound_en=1, busy=1, last=i, timer=0.
  - Also at that edge: clear pending[i], unless req[i] is asserted in the same cycle, in which case set wins.
  - State goes to PLAY.
- Latency: req high in cycle c (state IDLE, nothing pending) gives pending in cycle c+1 and sound_en in cycle c+2.
- PLAY: timer increments each cycle. sound_out is held stable, and later req/code changes do not alter it.
  - In the cycle where timer==DURATION-1, the next edge performs the exit:
    - sound_en=0, grant=0, sound_out=SILENCE, done[i]=1 for one cycle;
    - timer=0;
    - state goes to GAP if GAP>0, else IDLE.
  - sound_en is high for exactly DURATION cycles.
- GAP: busy=1, sound_en=0. When timer==GAP-1, the next edge goes to IDLE with busy=0. Requests keep queuing during GAP.
- Back-to-back: with GAP=0, the next grant occurs 1 cycle after the exit (one IDLE cycle between sounds).
- Simultaneous requests in the same cycle are all captured. They are served in RR order, one per PLAY.
- Fairness: a source continuously re-requesting cannot be granted twice in a row while another source is pending.
- The timer never wraps; it is cleared on each state entry.

Decomposition:
- Shared package sound_pkg:
  - state enum {IDLE, PLAY, GAP};
  - SOUND_W=6, SILENCE code, and the named sound codes used by game logic;
  - CLK_HZ=50_000_000.
- One sub-module, rr_picker: pending vector plus last index in, one-hot and index of the next owner out. Purely combinational.
- The FSM, timer and code registers stay in sound_arbiter.

Test Plan (NUM_REQ=4, DURATION=8, GAP=2):
- Single req[1] pulse with code1=6'b000_001 -> sound_en high cycles c+2..c+9 (8 cycles), sound_out=000_001, grant=4'b0010; done[1] pulse in cycle c+10; busy low from c+12.
- req=4'b1011 in one cycle with distinct codes -> grants in order 0, 1, 3. Each lasts 8 cycles with 2 silent cycles between; three done pulses arrive in the same order.
- req[2] re-pulsed with code 6'b000_111 while source 2 is playing 6'b000_011 -> the current sound stays 000_011; after GAP, a second PLAY with 000_111 and grant=4'b0100.
- req[0] held high continuously plus a req[3] pulse -> the grant sequence alternates 0, 3, 0. Source 0 never gets two consecutive grants while pending[3]=1.
- resetn high at PLAY cycle 4 -> next cycle sound_en=0, sound_out=SILENCE, grant=0, pending=0, no done pulse; after release, req[0] is served first.
- GAP=0 rebuild with req[0] and req[1] together -> exactly one IDLE cycle (sound_en=0) between the two 8-cycle PLAY windows.
